// File: rtl/rf_wb_sched_if.sv
// Write-back scheduler bus bundle.
// Groups the IDU scoreboard query/alloc signals, the three write-back
// requester handshakes (EXU, LSU, MDU) and the registered RF write port.
//   master : the surrounding pipeline (IDU, requesters, RF observer)
//   slave  : the scheduler itself
interface rf_wb_sched_if #(parameter int DATA_W = 32);
  logic              idu_sb_alloc_vld;
  logic [4:0]        idu_sb_alloc_addr;
  logic [4:0]        idu_sb_src1_addr;
  logic [4:0]        idu_sb_src2_addr;
  logic              sb_idu_src1_busy;
  logic              sb_idu_src2_busy;
  logic              sb_idu_rd_busy;

  logic              exu_wb_vld, lsu_wb_vld, mdu_wb_vld;
  logic [4:0]        exu_wb_addr, lsu_wb_addr, mdu_wb_addr;
  logic [DATA_W-1:0] exu_wb_data, lsu_wb_data, mdu_wb_data;
  logic              wb_exu_rdy, wb_lsu_rdy, wb_mdu_rdy;

  logic              sched_rf_wb_vld;
  logic [4:0]        sched_rf_wb_addr;
  logic [DATA_W-1:0] sched_rf_wb_data;

  modport slave (
    input  idu_sb_alloc_vld, idu_sb_alloc_addr, idu_sb_src1_addr, idu_sb_src2_addr,
    input  exu_wb_vld, lsu_wb_vld, mdu_wb_vld,
    input  exu_wb_addr, lsu_wb_addr, mdu_wb_addr,
    input  exu_wb_data, lsu_wb_data, mdu_wb_data,
    output sb_idu_src1_busy, sb_idu_src2_busy, sb_idu_rd_busy,
    output wb_exu_rdy, wb_lsu_rdy, wb_mdu_rdy,
    output sched_rf_wb_vld, sched_rf_wb_addr, sched_rf_wb_data
  );

  modport master (
    output idu_sb_alloc_vld, idu_sb_alloc_addr, idu_sb_src1_addr, idu_sb_src2_addr,
    output exu_wb_vld, lsu_wb_vld, mdu_wb_vld,
    output exu_wb_addr, lsu_wb_addr, mdu_wb_addr,
    output exu_wb_data, lsu_wb_data, mdu_wb_data,
    input  sb_idu_src1_busy, sb_idu_src2_busy, sb_idu_rd_busy,
    input  wb_exu_rdy, wb_lsu_rdy, wb_mdu_rdy,
    input  sched_rf_wb_vld, sched_rf_wb_addr, sched_rf_wb_data
  );
endinterface

// File: rtl/rf_wb_sched.sv
// Write-back scheduler + scoreboard in front of the single-write-port RF.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : rf_wb_sched_if.slave -- IDU alloc/query, EXU/LSU/MDU
//                write-back vld/rdy, registered RF write port
// Arbitration is combinational; the output register is always free, so a
// grant every cycle is sustainable. Requester index 0=EXU, 1=LSU, 2=MDU.
module rf_wb_sched #(
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  rf_wb_sched_if.slave    bus
);

  localparam int NREQ = 3;

  logic [NREQ-1:0]              req_vld, gnt;
  logic [NREQ-1:0][4:0]         req_addr;
  logic [NREQ-1:0][DATA_W-1:0]  req_data;
  logic [1:0]                   rr_ptr;
  logic [4:0]                   sel_addr;
  logic [DATA_W-1:0]            sel_data;
  logic [1:0]                   sel_idx;
  logic                         hs;

  logic                         wb_vld_q;
  logic [4:0]                   wb_addr_q;
  logic [DATA_W-1:0]            wb_data_q;
  logic [31:0]                  busy;

  assign req_vld  = {bus.mdu_wb_vld,  bus.lsu_wb_vld,  bus.exu_wb_vld};
  assign req_addr = {bus.mdu_wb_addr, bus.lsu_wb_addr, bus.exu_wb_addr};
  assign req_data = {bus.mdu_wb_data, bus.lsu_wb_data, bus.exu_wb_data};

  // First valid requester in the search order starting at 'first'.
  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v, input logic [1:0] first);
    logic [NREQ-1:0] g;
    logic [1:0]      idx;
    g = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      idx = 2'((32'(first) + i) % NREQ);
      if (v[idx]) g = '0;
      if (v[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  always_comb begin
    if (RR_EN) gnt = pick(req_vld, rr_ptr);
    else       gnt = pick(req_vld, 2'd1);   // LSU > MDU > EXU
  end

  assign hs = |gnt;
  assign {bus.wb_mdu_rdy, bus.wb_lsu_rdy, bus.wb_exu_rdy} = gnt;

  always_comb begin
    sel_idx  = 2'd0;
    sel_addr = req_addr[0];
    sel_data = req_data[0];
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_idx  = 2'(i);
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= 2'd0;
    else if (RR_EN && hs) rr_ptr <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
  end

  // Registered RF write; x0 writes are accepted but never reach the RF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_vld_q <= hs && (sel_addr != 5'd0);
      if (hs) begin
        wb_addr_q <= sel_addr;
        wb_data_q <= sel_data;
      end
    end
  end

  assign bus.sched_rf_wb_vld  = wb_vld_q;
  assign bus.sched_rf_wb_addr = wb_addr_q;
  assign bus.sched_rf_wb_data = wb_data_q;

  // Scoreboard: clear when the RF write is on the port, set on alloc;
  // set wins so a new writer of the same rd stays pending.
  assign busy[0] = 1'b0;
  for (genvar r = 1; r < 32; r++) begin : g_busy
    logic set_r, clr_r;
    assign set_r = bus.idu_sb_alloc_vld && (bus.idu_sb_alloc_addr == 5'(r));
    assign clr_r = wb_vld_q && (wb_addr_q == 5'(r));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy[r] <= 1'b0;
      else        busy[r] <= set_r | (busy[r] & ~clr_r);
    end
  end

  assign bus.sb_idu_src1_busy = busy[bus.idu_sb_src1_addr];
  assign bus.sb_idu_src2_busy = busy[bus.idu_sb_src2_addr];
  assign bus.sb_idu_rd_busy   = busy[bus.idu_sb_alloc_addr];

  // Double allocation of a pending rd collapses to one bit; IDU must stall.
  a_no_waw_alloc: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.idu_sb_alloc_vld && bus.idu_sb_alloc_addr != 5'd0 && bus.sb_idu_rd_busy));

endmodule
